// File: rtl/frame_sequencer.sv
// Frame sequencer: runs erase, wave, collision-check and ship-draw units in turn
// for each frame_tick, muxes their pixel ports, and tracks game-over/fault/overrun.
module frame_sequencer #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        dir_in,
  input  logic [3:0]  unit_done,
  input  logic        collision_in,
  input  logic [31:0] src_x,
  input  logic [27:0] src_y,
  input  logic [11:0] src_colour,
  input  logic [3:0]  src_writeEn,
  output logic [3:0]  unit_start,
  output logic        shipDir,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        busy,
  output logic        game_over,
  output logic        fault,
  output logic        overrun,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_WAVE  = 3'd2,
    S_CHECK = 3'd3,
    S_DRAW  = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  // Sub-steps: 0 = start pulse, 1 = guard, 2 = waiting for done, 3 = done seen.
  localparam logic [1:0]  STEP_START = 2'd0;
  localparam logic [1:0]  STEP_GUARD = 2'd1;
  localparam logic [1:0]  STEP_WAIT  = 2'd2;
  localparam logic [1:0]  STEP_DONE  = 2'd3;
  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0]  start_q, start_d;
  logic        dir_q, dir_d;
  logic        over_q, over_d;
  logic        fault_q, fault_d;
  logic        ovr_q, ovr_d;
  logic        coll_q, coll_d;
  logic        done_act;
  logic        in_phase;

  // Pixel port and done routing follow the active unit only.
  always_comb begin
    x        = '0;
    y        = '0;
    colour   = '0;
    writeEn  = 1'b0;
    done_act = 1'b0;
    in_phase = 1'b1;
    case (state_q)
      S_ERASE: begin
        x = src_x[7:0];   y = src_y[6:0];   colour = src_colour[2:0];
        writeEn = src_writeEn[0]; done_act = unit_done[0];
      end
      S_WAVE: begin
        x = src_x[15:8];  y = src_y[13:7];  colour = src_colour[5:3];
        writeEn = src_writeEn[1]; done_act = unit_done[1];
      end
      S_CHECK: begin
        x = src_x[23:16]; y = src_y[20:14]; colour = src_colour[8:6];
        writeEn = src_writeEn[2]; done_act = unit_done[2];
      end
      S_DRAW: begin
        x = src_x[31:24]; y = src_y[27:21]; colour = src_colour[11:9];
        writeEn = src_writeEn[3]; done_act = unit_done[3];
      end
      default: in_phase = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    start_d = '0;
    dir_d   = dir_q;
    over_d  = over_q;
    fault_d = fault_q;
    ovr_d   = ovr_q;
    coll_d  = coll_q;

    if (frame_tick && in_phase) ovr_d = 1'b1;

    if (state_q == S_IDLE) begin
      if (frame_tick && !over_q) begin
        state_d = S_ERASE;
        step_d  = STEP_START;
        cnt_d   = '0;
        start_d = 4'b0001;
        dir_d   = dir_in;
        coll_d  = 1'b0;
      end
    end else if (in_phase) begin
      cnt_d = cnt_q + 12'd1;
      if (state_q == S_CHECK && step_q[1] && collision_in) coll_d = 1'b1;
      case (step_q)
        STEP_START: step_d = STEP_GUARD;
        STEP_GUARD: step_d = STEP_WAIT;
        STEP_WAIT:  if (done_act) step_d = STEP_DONE;
        default: begin
          step_d = STEP_START;
          cnt_d  = '0;
          case (state_q)
            S_ERASE: begin state_d = S_WAVE; start_d = 4'b0010; end
            S_WAVE:  begin state_d = S_CHECK; start_d = 4'b0100; end
            S_CHECK: begin
              if (coll_q || collision_in) begin
                state_d = S_OVER;
                over_d  = 1'b1;
              end else begin
                state_d = S_DRAW;
                start_d = 4'b1000;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      endcase
      // A phase that has not completed by its last allowed cycle abandons the frame.
      if (step_q != STEP_DONE && !(step_q == STEP_WAIT && done_act) && cnt_q == TIMEOUT_LAST) begin
        state_d = S_IDLE;
        step_d  = STEP_START;
        cnt_d   = '0;
        fault_d = 1'b1;
        coll_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      dir_q   <= 1'b0;
      over_q  <= 1'b0;
      fault_q <= 1'b0;
      ovr_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      dir_q   <= dir_d;
      over_q  <= over_d;
      fault_q <= fault_d;
      ovr_q   <= ovr_d;
      coll_q  <= coll_d;
    end
  end

  assign unit_start = start_q;
  assign shipDir    = dir_q;
  assign game_over  = over_q;
  assign fault      = fault_q;
  assign overrun    = ovr_q;
  assign phase      = state_q;
  assign busy       = in_phase;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: table of whole-frame scenarios plus
// hand-written sequences for pixel muxing, inactive done and mid-frame reset.
module tb_frame_sequencer;

  localparam int TO = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        dir_in;
  logic [3:0]  unit_done;
  logic        collision_in;
  logic [31:0] src_x;
  logic [27:0] src_y;
  logic [11:0] src_colour;
  logic [3:0]  src_writeEn;
  logic [3:0]  unit_start;
  logic        shipDir;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        busy;
  logic        game_over;
  logic        fault;
  logic        overrun;
  logic [2:0]  phase;

  int checks = 0;
  int failures = 0;

  frame_sequencer #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .dir_in(dir_in),
    .unit_done(unit_done), .collision_in(collision_in), .src_x(src_x),
    .src_y(src_y), .src_colour(src_colour), .src_writeEn(src_writeEn),
    .unit_start(unit_start), .shipDir(shipDir), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .busy(busy), .game_over(game_over), .fault(fault),
    .overrun(overrun), .phase(phase)
  );

  always #5 clock = ~clock;

  // Cycle numbers in the table are relative to the cycle frame_tick is high (0).
  typedef struct {
    int dir; int coll_rel; int tick2_rel; int block; int len;
    int s0; int s1; int s2; int s3;
    int idle_at; int fault_at; int end_phase; int ship; int go; int ovr; int nstarts;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b0; dir_in = 1'b0; unit_done = '0; collision_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int st[4];
    int nstarts = 0;
    int idle_at = -1;
    int fault_at = -1;
    int viol = 0;
    logic [3:0] prev = '0;
    for (int i = 0; i < 4; i++) st[i] = -1;
    do_reset();
    dir_in = (v.dir != 0);
    frame_tick = 1'b1;
    for (int r = 1; r <= v.len; r++) begin
      step();
      if ($countones(unit_start) > 1 || (unit_start & prev) != 4'b0) viol++;
      if (unit_start != 4'b0) nstarts++;
      for (int i = 0; i < 4; i++) if (unit_start[i] && st[i] < 0) st[i] = r;
      prev = unit_start;
      if (idle_at < 0 && phase == 3'd0) idle_at = r;
      if (fault_at < 0 && fault) fault_at = r;
      frame_tick   = (r == v.tick2_rel);
      collision_in = (r == v.coll_rel);
      for (int i = 0; i < 4; i++) unit_done[i] = (st[i] >= 0 && r == st[i] + 5 && i != v.block);
    end
    check($sformatf("v%0d_start0", idx), st[0], v.s0);
    check($sformatf("v%0d_start1", idx), st[1], v.s1);
    check($sformatf("v%0d_start2", idx), st[2], v.s2);
    check($sformatf("v%0d_start3", idx), st[3], v.s3);
    check($sformatf("v%0d_nstarts", idx), nstarts, v.nstarts);
    check($sformatf("v%0d_pulse_rule", idx), viol, 0);
    check($sformatf("v%0d_idle_at", idx), idle_at, v.idle_at);
    check($sformatf("v%0d_fault_at", idx), fault_at, v.fault_at);
    check($sformatf("v%0d_phase", idx), int'(phase), v.end_phase);
    check($sformatf("v%0d_shipdir", idx), int'(shipDir), v.ship);
    check($sformatf("v%0d_game_over", idx), int'(game_over), v.go);
    check($sformatf("v%0d_overrun", idx), int'(overrun), v.ovr);
    check($sformatf("v%0d_busy", idx), int'(busy), 0);
  endtask

  initial begin
    //           dir coll tick2 blk len  s0 s1  s2  s3  idle fault ph ship go ovr n
    vecs[0] = '{1,  -1,  -1,  -1, 40,  1, 8, 15, 22,  29,  -1, 0, 1, 0, 0, 4}; // normal
    vecs[1] = '{1,  18,  30,  -1, 36,  1, 8, 15, -1,  -1,  -1, 5, 1, 1, 0, 3}; // collision, late tick
    vecs[2] = '{0,  -1,  -1,   1, 40,  1, 8, -1, -1,  28,  28, 0, 0, 0, 0, 2}; // wave timeout
    vecs[3] = '{1,  -1,  17,  -1, 45,  1, 8, 15, 22,  29,  -1, 0, 1, 0, 1, 4}; // overrun in check
    vecs[4] = '{0,  20,  -1,  -1, 30,  1, 8, 15, -1,  -1,  -1, 5, 0, 1, 0, 3}; // collision with done
    vecs[5] = '{1,  16,  -1,  -1, 40,  1, 8, 15, 22,  29,  -1, 0, 1, 0, 0, 4}; // collision in guard

    src_x = '0; src_y = '0; src_colour = '0; src_writeEn = '0;
    do_reset();
    check("rst_phase", int'(phase), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(unit_start), 0);
    check("rst_flags", int'({shipDir, game_over, fault, overrun}), 0);
    check("rst_pixel", int'({x, y, colour, writeEn}), 0);

    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // Pixel mux isolation; unit 0 done held high must not end WAVE.
    do_reset();
    src_x = {8'd44, 8'd33, 8'd22, 8'd11};
    src_y = {7'd40, 7'd30, 7'd20, 7'd10};
    src_colour = {3'd4, 3'd3, 3'd2, 3'd1};
    src_writeEn = 4'b1111;
    step();
    check("mux_idle_we", int'(writeEn), 0);
    check("mux_idle_x", int'(x), 0);
    unit_done = 4'b0001;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("mux_erase_x", int'(x), 11);
    for (int k = 0; k < 12 && phase != 3'd2; k++) step();
    check("mux_reach_wave", int'(phase), 2);
    check("mux_wave_x", int'(x), 22);
    check("mux_wave_y", int'(y), 20);
    check("mux_wave_colour", int'(colour), 2);
    check("mux_wave_we", int'(writeEn), 1);
    for (int k = 0; k < 6; k++) step();
    check("inactive_done_ignored", int'(phase), 2);
    src_writeEn = 4'b0010;
    check("mux_wave_we_own", int'(writeEn), 1);
    src_writeEn = 4'b1101;
    #1;
    check("mux_wave_we_other", int'(writeEn), 0);

    // Reset in the middle of DRAW clears everything, including sticky flags.
    do_reset();
    unit_done = 4'b1111;
    dir_in = 1'b1;
    frame_tick = 1'b1;
    step();
    step();
    check("mid_overrun_set", int'(overrun), 1);
    frame_tick = 1'b0;
    for (int k = 0; k < 30 && phase != 3'd4; k++) step();
    check("mid_reach_draw", int'(phase), 4);
    check("mid_shipdir", int'(shipDir), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    unit_done = '0;
    check("mid_rst_phase", int'(phase), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_start", int'(unit_start), 0);
    check("mid_rst_flags", int'({shipDir, game_over, fault, overrun}), 0);
    step();
    check("post_rst_no_start", int'(unit_start), 0);
    check("post_rst_idle", int'(phase), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
